// File: rtl/fp16_acc_stage.sv
// fp16_acc_stage: sums len_59 half-precision products into a 16-bit accumulator.
// Single-cycle adder that truncates, flushes subnormals and saturates to infinity.
module fp16_acc_stage #(
    parameter int LEN_W = 8
) (
    input  logic             clk_59,
    input  logic             reset_59,
    input  logic             start_59,
    input  logic [LEN_W-1:0] len_59,
    input  logic [15:0]      prod_59,
    input  logic             prod_valid_59,
    output logic             prod_ready_59,
    output logic [15:0]      sum_59,
    output logic             done_59,
    output logic             busy_59
);
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_ACC  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic [1:0]        state_q, state_d;
    logic [15:0]       acc_q, acc_d;
    logic [LEN_W-1:0]  cnt_q, cnt_d;
    logic              done_q, done_d;

    logic              a_inf, b_inf, a_zero, b_zero, a_big, s_res;
    logic [14:0]       key_a, key_b;
    logic [4:0]        e_big, e_small, e_diff;
    logic [13:0]       m_a, m_b, m_big, m_small;
    logic [14:0]       mag;
    logic [3:0]        top, lz;
    logic signed [6:0] e_res;
    logic [9:0]        f_res;
    logic [15:0]       add_res;

    always_comb begin
        a_inf  = acc_q[14:10] == 5'h1F;
        b_inf  = prod_59[14:10] == 5'h1F;
        a_zero = acc_q[14:10] == 5'h00;
        b_zero = prod_59[14:10] == 5'h00;
        // Subnormals carry no weight: zero both the compare key and the mantissa.
        key_a  = a_zero ? 15'd0 : acc_q[14:0];
        key_b  = b_zero ? 15'd0 : prod_59[14:0];
        m_a    = a_zero ? 14'd0 : {1'b1, acc_q[9:0], 3'b000};
        m_b    = b_zero ? 14'd0 : {1'b1, prod_59[9:0], 3'b000};
        a_big  = key_a >= key_b;

        e_big   = a_big ? acc_q[14:10] : prod_59[14:10];
        e_small = a_big ? prod_59[14:10] : acc_q[14:10];
        m_big   = a_big ? m_a : m_b;
        m_small = a_big ? m_b : m_a;
        s_res   = a_big ? acc_q[15] : prod_59[15];
        e_diff  = e_big - e_small;

        if (acc_q[15] == prod_59[15]) begin
            mag = {1'b0, m_big} + {1'b0, m_small >> e_diff};
        end else begin
            mag = {1'b0, m_big} - {1'b0, m_small >> e_diff};
        end

        top = 4'd0;
        for (int i = 0; i < 14; i++) begin
            if (mag[i]) top = 4'(i);
        end
        lz = 4'd13 - top;

        if (mag[14]) begin
            e_res = $signed({2'b00, e_big}) + 7'sd1;
            f_res = mag[13:4];
        end else begin
            e_res = $signed({2'b00, e_big}) - $signed({3'b000, lz});
            f_res = 10'((mag[12:0] << lz) >> 3);
        end

        // Equal magnitudes of opposite sign cancel to mag == 0 and land on +0.
        if (a_inf || b_inf) begin
            if (a_inf && b_inf && (acc_q[15] != prod_59[15])) add_res = 16'h7C00;
            else add_res = {(a_inf ? acc_q[15] : prod_59[15]), 15'h7C00};
        end else if (mag == 15'd0) begin
            add_res = 16'h0000;
        end else if (e_res >= 7'sd31) begin
            add_res = {s_res, 15'h7C00};
        end else if (e_res <= 7'sd0) begin
            add_res = 16'h0000;
        end else begin
            add_res = {s_res, e_res[4:0], f_res};
        end
    end

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start_59) begin
                    acc_d = 16'h0000;
                    if (len_59 == '0) begin
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = ST_ACC;
                        cnt_d   = len_59;
                    end
                end
            end
            ST_ACC: begin
                if (prod_valid_59) begin
                    acc_d = add_res;
                    cnt_d = cnt_q - LEN_W'(1);
                    if (cnt_q == LEN_W'(1)) begin
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_59) begin
        if (reset_59) begin
            state_q <= ST_IDLE;
            acc_q   <= 16'h0000;
            cnt_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
        end
    end

    assign prod_ready_59 = state_q == ST_ACC;
    assign busy_59       = state_q == ST_ACC;
    assign sum_59        = acc_q;
    assign done_59       = done_q;
endmodule

// File: tb/tb_fp16_acc_stage.sv
// Bench for fp16_acc_stage: directed vector table, reset corner sequences and
// randomized transactions checked against an integer-arithmetic FP16 model.
module tb_fp16_acc_stage;
    localparam int LEN_W = 8;

    logic             clk;
    logic             reset;
    logic             start;
    logic [LEN_W-1:0] len_i;
    logic [15:0]      prod;
    logic             prod_valid;
    logic             prod_ready;
    logic [15:0]      sum;
    logic             done;
    logic             busy;

    int n_cmp = 0;
    int n_err = 0;

    logic [15:0] pv[8];
    int          gp[8];

    typedef struct {
        int          len;
        logic [15:0] p0;
        logic [15:0] p1;
        logic [15:0] p2;
        int          gap1;
        logic [15:0] want;
    } vec_t;

    vec_t tv[16];

    fp16_acc_stage #(.LEN_W(LEN_W)) dut (
        .clk_59       (clk),
        .reset_59     (reset),
        .start_59     (start),
        .len_59       (len_i),
        .prod_59      (prod),
        .prod_valid_59(prod_valid),
        .prod_ready_59(prod_ready),
        .sum_59       (sum),
        .done_59      (done),
        .busy_59      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk1(input string nm, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %b, expected %b", nm, act, exp);
        end
    endtask

    task automatic chk16(input string nm, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    // Value-level model: operands as integer mantissas scaled by 8 (three guard bits).
    function automatic logic [15:0] ref_add(input logic [15:0] a, input logic [15:0] b);
        int ea, eb, ka, kb, ma, mb, ml, ms, v, e;
        logic sl;
        ea = int'(a[14:10]);
        eb = int'(b[14:10]);
        if (ea == 31 || eb == 31) begin
            if (ea == 31 && eb == 31 && a[15] != b[15]) return 16'h7C00;
            return {((ea == 31) ? a[15] : b[15]), 15'h7C00};
        end
        ka = (ea == 0) ? 0 : int'(a[14:0]);
        kb = (eb == 0) ? 0 : int'(b[14:0]);
        if (ka == kb && a[15] != b[15]) return 16'h0000;
        ma = (ea == 0) ? 0 : (1024 + int'(a[9:0])) * 8;
        mb = (eb == 0) ? 0 : (1024 + int'(b[9:0])) * 8;
        if (ka >= kb) begin
            ml = ma; ms = mb >> (ea - eb); e = ea; sl = a[15];
        end else begin
            ml = mb; ms = ma >> (eb - ea); e = eb; sl = b[15];
        end
        v = (a[15] == b[15]) ? ml + ms : ml - ms;
        if (v == 0) return 16'h0000;
        while (v >= 16384) begin v = v / 2; e++; end
        while (v < 8192) begin v = v * 2; e--; end
        if (e >= 31) return {sl, 15'h7C00};
        if (e <= 0) return 16'h0000;
        return {sl, 5'(e), 10'((v / 8) % 1024)};
    endfunction

    function automatic logic [15:0] rand_prod();
        logic [15:0] p;
        p = 16'($urandom);
        case ($urandom_range(0, 3))
            1, 2:    p[14:10] = 5'($urandom_range(12, 18));
            3:       p[14:10] = 5'($urandom_range(27, 30));
            default: ;
        endcase
        return p;
    endfunction

    // Issues one start from IDLE/DONE, feeds pv[]/gp[] and checks the done pulse.
    task automatic do_txn(input string nm, input int len, input logic [15:0] want);
        start = 1'b1; len_i = LEN_W'(len); prod_valid = 1'b1; prod = 16'h5555;
        step();
        start = 1'b0; prod_valid = 1'b0;
        chk1({nm, "_busy0"}, busy, len != 0);
        for (int i = 0; i < len; i++) begin
            for (int g = 0; g < gp[i]; g++) begin
                start = 1'($urandom_range(0, 1)); len_i = LEN_W'($urandom); prod = 16'($urandom);
                step();
                chk1({nm, "_gap_busy"}, busy, 1'b1);
                chk1({nm, "_gap_done"}, done, 1'b0);
            end
            start = 1'b0; prod_valid = 1'b1; prod = pv[i];
            chk1({nm, "_ready"}, prod_ready, 1'b1);
            step();
            prod_valid = 1'b0;
            if (i < len - 1) chk1({nm, "_early_done"}, done, 1'b0);
        end
        chk1({nm, "_done"}, done, 1'b1);
        chk16({nm, "_sum"}, sum, want);
        chk1({nm, "_ready_done"}, prod_ready, 1'b0);
        prod_valid = 1'b1; prod = 16'($urandom);
        step();
        prod_valid = 1'b0;
        chk1({nm, "_done_pulse"}, done, 1'b0);
        chk16({nm, "_sum_hold"}, sum, want);
        chk1({nm, "_busy_end"}, busy, 1'b0);
    endtask

    initial begin
        logic [15:0] want;
        int          len;

        tv[0]  = '{3, 16'h3C00, 16'h4000, 16'h4200, 0, 16'h4600};
        tv[1]  = '{0, 16'h0000, 16'h0000, 16'h0000, 0, 16'h0000};
        tv[2]  = '{2, 16'h4000, 16'hC000, 16'h0000, 3, 16'h0000};
        tv[3]  = '{2, 16'h7BFF, 16'h7BFF, 16'h0000, 0, 16'h7C00};
        tv[4]  = '{2, 16'h0200, 16'h3C00, 16'h0000, 0, 16'h3C00};
        tv[5]  = '{2, 16'h3C00, 16'hBC00, 16'h0000, 0, 16'h0000};
        tv[6]  = '{2, 16'h7C00, 16'hFC00, 16'h0000, 0, 16'h7C00};
        tv[7]  = '{2, 16'hFC00, 16'h3C00, 16'h0000, 0, 16'hFC00};
        tv[8]  = '{2, 16'h4000, 16'hBC00, 16'h0000, 0, 16'h3C00};
        tv[9]  = '{2, 16'h0800, 16'h8400, 16'h0000, 0, 16'h0400};
        tv[10] = '{2, 16'h0600, 16'h8400, 16'h0000, 0, 16'h0000};
        tv[11] = '{2, 16'h3C01, 16'hB800, 16'h0000, 1, 16'h3802};
        tv[12] = '{2, 16'h3C00, 16'h8C00, 16'h0000, 0, 16'h3BFF};
        tv[13] = '{3, 16'h3C00, 16'h1000, 16'h1000, 0, 16'h3C00};
        tv[14] = '{1, 16'h7E00, 16'h0000, 16'h0000, 0, 16'h7C00};
        tv[15] = '{2, 16'h0400, 16'h8000, 16'h0000, 0, 16'h0400};

        reset = 1'b1; start = 1'b0; len_i = '0; prod = 16'h0000; prod_valid = 1'b0;
        step();
        start = 1'b1; len_i = LEN_W'(3); prod_valid = 1'b1; prod = 16'h3C00;
        step();
        chk16("rst_sum", sum, 16'h0000);
        chk1("rst_busy", busy, 1'b0);
        chk1("rst_ready", prod_ready, 1'b0);
        chk1("rst_done", done, 1'b0);
        reset = 1'b0; start = 1'b0; prod_valid = 1'b0;
        step();
        chk1("idle_done", done, 1'b0);
        chk1("idle_ready", prod_ready, 1'b0);

        for (int k = 0; k < 16; k++) begin
            pv[0] = tv[k].p0; pv[1] = tv[k].p1; pv[2] = tv[k].p2;
            gp[0] = 0; gp[1] = tv[k].gap1; gp[2] = 0;
            do_txn($sformatf("tv%0d", k), tv[k].len, tv[k].want);
        end

        // Reset while sitting in DONE clears the held sum.
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk16("rst_in_done_sum", sum, 16'h0000);
        chk1("rst_in_done_done", done, 1'b0);

        // Reset mid-ACC after two accepted products, colliding with start and valid.
        start = 1'b1; len_i = LEN_W'(4);
        step();
        start = 1'b0; prod_valid = 1'b1; prod = 16'h3C00;
        step();
        prod = 16'h4000;
        step();
        chk16("midacc_partial", sum, 16'h4200);
        reset = 1'b1; start = 1'b1; len_i = LEN_W'(1); prod = 16'h4000;
        step();
        reset = 1'b0; start = 1'b0; prod_valid = 1'b0;
        chk16("midacc_rst_sum", sum, 16'h0000);
        chk1("midacc_rst_busy", busy, 1'b0);
        chk1("midacc_rst_done", done, 1'b0);
        for (int c = 0; c < 3; c++) begin
            prod_valid = 1'b1; prod = 16'h3C00;
            step();
            chk1("midacc_after_done", done, 1'b0);
            chk1("midacc_after_ready", prod_ready, 1'b0);
        end
        prod_valid = 1'b0;
        pv[0] = 16'h3C00; gp[0] = 0;
        do_txn("post_rst", 1, 16'h3C00);

        for (int t = 0; t < 60; t++) begin
            len  = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 6));
            want = 16'h0000;
            for (int i = 0; i < len; i++) begin
                pv[i] = rand_prod();
                gp[i] = $urandom_range(0, 2);
                want  = ref_add(want, pv[i]);
            end
            do_txn($sformatf("rnd%0d", t), len, want);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
